// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serializer.
// Holds the FSM state encoding, bit-order encodings and counter sizing.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit ORDER_MSB_FIRST = 1'b0;
    localparam bit ORDER_LSB_FIRST = 1'b1;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry word buffer that decouples the upstream handshake from the shifter.
// A write has priority over a read strobe; clr empties the entry.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_valid,
    input  logic             i_rd,
    output logic             o_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;
    logic             w_wr;

    assign o_ready = !r_full && !i_clr;
    assign w_wr    = i_wr_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end else if (w_wr) begin
            r_data <= i_wr_data;
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-word holding buffer so words stream
// back-to-back; shift_en paces each bit, bit order and idle level are parameters.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = ORDER_MSB_FIRST,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_last;
    logic             w_step;
    logic             w_load;
    logic             w_cur_bit;
    logic [WIDTH-1:0] w_shift_next;

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (clr),
        .i_wr_data (in_data),
        .i_wr_valid(in_valid),
        .i_rd      (w_load),
        .o_ready   (in_ready),
        .o_full    (w_hold_full),
        .o_data    (w_hold_data)
    );

    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_cur_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end else begin : g_msb
            assign w_cur_bit    = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end
    endgenerate

    assign w_last = (r_cnt == LAST_CNT);
    assign w_step = (r_state == SHIFT) && shift_en;
    // Reload either from idle or on the edge that consumes the last bit: no gap bits.
    assign w_load = w_hold_full && !clr && ((r_state == IDLE) || (w_step && w_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_step && w_last;
            if (w_load) begin
                r_shift <= w_hold_data;
                r_cnt   <= '0;
                r_state <= SHIFT;
            end else if (w_step) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign serial_out   = (r_state == SHIFT) ? w_cur_bit : IDLE_LEVEL;
    assign serial_valid = (r_state == SHIFT);
    assign frame_start  = (r_state == SHIFT) && (r_cnt == '0);
    assign busy         = (r_state == SHIFT) || w_hold_full;
    assign done         = r_done;

endmodule

// File: tb/tb_piso_stream.sv
// Randomised scoreboard bench for piso_stream: two configurations (MSB-first/idle 0
// and LSB-first/idle 1) share the stimulus, each with its own expected-bit queue.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       end_phase = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
            localparam int W   = (gi == 0) ? 4 : 5;
            localparam bit LSB = (gi == 1);
            localparam bit IDL = (gi == 1);

            logic ir, so, sv, fs, bz, dn;
            // Each entry: {last bit of word, first bit of word, bit value}
            logic [2:0] exp_q[$];
            int outst = 0;
            bit exp_done = 1'b0;
            int lat = 0;

            piso_stream #(
                .WIDTH     (W),
                .LSB_FIRST (LSB),
                .IDLE_LEVEL(IDL)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .clr         (clr),
                .in_data     (in_data[W-1:0]),
                .in_valid    (in_valid),
                .in_ready    (ir),
                .shift_en    (shift_en),
                .serial_out  (so),
                .serial_valid(sv),
                .frame_start (fs),
                .busy        (bz),
                .done        (dn)
            );

            task automatic chk(input string name, input logic act, input logic req);
                n_tests++;
                if (act !== req) begin
                    n_fail++;
                    $display("FAIL cfg%0d %s: got %b, required %b at %0t", gi, name, act, req, $time);
                end
            endtask

            // Monitor: compare what is on the outputs now, then advance the model
            // by what the coming edge will do with the inputs now applied.
            always @(negedge clk) begin
                if (!rst) begin
                    logic [2:0] e;
                    logic [2:0] ent;
                    int idx;
                    chk("done", dn, exp_done);
                    chk("busy", bz, outst > 0);
                    if (clr) chk("in_ready_clr", ir, 1'b0);
                    else if (outst == 0) chk("in_ready_empty", ir, 1'b1);
                    else if (outst >= 2) chk("in_ready_full", ir, 1'b0);
                    if (lat == 1) begin
                        chk("latency_gap", sv, 1'b0);
                        lat = 2;
                    end else if (lat == 2) begin
                        chk("latency_first", sv && fs, 1'b1);
                        lat = 0;
                    end
                    if (sv) begin
                        if (exp_q.size() == 0) begin
                            chk("spurious_bit", sv, 1'b0);
                        end else begin
                            e = exp_q[0];
                            chk("serial_out", so, e[0]);
                            chk("frame_start", fs, e[1]);
                        end
                    end else begin
                        chk("idle_level", so, IDL);
                        chk("frame_start_idle", fs, 1'b0);
                    end

                    exp_done = 1'b0;
                    if (clr) begin
                        exp_q.delete();
                        outst = 0;
                        lat = 0;
                    end else begin
                        if (sv && shift_en && exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            if (e[2]) begin
                                exp_done = 1'b1;
                                outst--;
                            end
                        end
                        if (in_valid && ir) begin
                            if (outst == 0) lat = 1;
                            for (int i = 0; i < W; i++) begin
                                idx = LSB ? i : (W - 1 - i);
                                ent = {(i == W - 1), (i == 0), in_data[idx]};
                                exp_q.push_back(ent);
                            end
                            outst++;
                        end
                    end
                end
            end

            always @(posedge rst) begin
                #1;
                chk("rst_serial_valid", sv, 1'b0);
                chk("rst_busy", bz, 1'b0);
                chk("rst_done", dn, 1'b0);
                chk("rst_serial_out", so, IDL);
                chk("rst_frame_start", fs, 1'b0);
                exp_q.delete();
                outst = 0;
                exp_done = 1'b0;
                lat = 0;
            end

            always @(posedge end_phase) begin
                chk("drained_busy", bz, 1'b0);
                n_tests++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL cfg%0d drain: %0d expected bits never shifted out, required 0", gi, exp_q.size());
                end
            end
        end
    endgenerate

    initial begin
        int mode;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            mode = (cyc / 500) % 3;
            if (mode == 0) shift_en = 1'b1;
            else if (mode == 1) shift_en = (cyc % 3 == 0);
            else shift_en = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = 8'($urandom);
            clr      = ($urandom_range(0, 199) == 0);
            if (cyc % 617 == 300) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        shift_en = 1'b1;
        repeat (30) @(posedge clk);
        #1 end_phase = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in/serial-out shifter with a valid/ready word interface and a one-entry holding buffer, so words stream back-to-back with no gap bits. Bit order and idle line level are set by parameters. A bit-rate enable (shift_en) paces the output, so the block drives a serial link directly, either at full clock rate or at a divided rate.

Parameters:
WIDTH, 8, bits per word (>= 2)
LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB first
IDLE_LEVEL, 0, serial_out value while no word is being shifted

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush; drops held and in-flight words
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word
shift_en  input  1  advance one bit at this edge
serial_out  output  1  serial bit
serial_valid  output  1  serial_out carries a data bit
frame_start  output  1  high while the first bit of a word is on serial_out
busy  output  1  a word is being shifted or is held
done  output  1  one-cycle pulse after the last bit of a word is consumed

Behaviour:
- Reset (async, immediate): state=IDLE, hold_full=0, bit count=0, serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0, busy=0, done=0, in_ready=1 once rst deasserts.
- in_ready = !hold_full && !clr. No combinational path from shift_en.
- Accept: in_valid && in_ready at an edge -> in_data is written to the hold register and hold_full=1.
- States:
  - IDLE: if hold_full at an edge, transfer hold -> shift register, hold_full=0 (unless refilled at the same edge), cnt=0, go to SHIFT.
  - SHIFT: serial_out = current bit, MSB or LSB per LSB_FIRST; serial_valid=1.
    - At an edge with shift_en=1 and cnt<WIDTH-1: shift one position, cnt++.
    - At an edge with shift_en=1 and cnt==WIDTH-1: done=1 for the next cycle. If hold_full, load the next word at that same edge (cnt=0, stay in SHIFT, zero gap bits). Otherwise go to IDLE.
  - With shift_en=0 the current bit is held indefinitely.
- Latency: word accepted at edge E0 -> transferred at E1 -> first bit on serial_out after E1.
- frame_start = (state==SHIFT && cnt==0).
- busy = (state==SHIFT) || hold_full.
- Simultaneous transfer-out and accept: legal only if in_ready was already high. The hold register takes the new word while the old word moves to the shifter.
- clr=1 at an edge: state=IDLE, hold_full=0, no accept at that edge, and no done pulse.
- Reset asserted mid-word: the word is lost, all outputs return to reset values asynchronously, and no done pulse is issued.
- IDLE: serial_out = IDLE_LEVEL, serial_valid=0.
- Counter width is $clog2(WIDTH); the counter never wraps past WIDTH-1.

Decomposition:
- Package piso_pkg holds:
  - state enum typedef (IDLE, SHIFT)
  - function for counter width, clog2 with a minimum of 1
  - bit-order localparam encodings
- One natural sub-module, piso_hold_buf: single-entry register with full flag, write/read strobes and ready generation. The top level holds the FSM, shift register and counter.

Test Plan:
- WIDTH=4, MSB-first, shift_en=1; send 4'b1001 accepted at E0 -> serial_out 1,0,0,1 on the cycles after E1..E4; frame_start high only after E1; done high one cycle after E5; serial_out=IDLE_LEVEL after E5.
- Back-to-back: 1001 then 1100 (second accepted at E2) -> continuous 1,0,0,1,1,1,0,0 with no gap bit; done pulses after E5 and after E9; in_ready low E2..E5.
- LSB_FIRST=1, word 4'b0110, shift_en high every 3rd cycle -> bits 0,1,1,0, each held for 3 cycles; serial_valid stays high throughout.
- Hold full plus shifting: in_valid held high with a third word 0110 -> not accepted until the hold register empties; no word dropped or duplicated; output 1001 1100 0110.
- clr asserted during bit 2 of a word with a held word and in_valid=1 -> next cycle IDLE, busy=0, no done, the held word and the offered word are both discarded.
- rst pulsed asynchronously mid-word (between edges) -> outputs reset immediately; a new word after release shifts correctly from bit 0.
